branch_predictor: RTL

// - Fetch-stage dynamic branch predictor: 2-bit saturating-counter BHT plus direct-mapped BTB.
// - Predicts direction/target for the fetch PC in the same cycle; trained by the execute-stage branch

---
 rtl/branch_predictor_pkg.sv | 16 +
 rtl/branch_predictor_sat_ctr2.sv | 19 +
 rtl/branch_predictor.sv | 106 ++++++++++
 3 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-stage branch predictor: datapath width,
// default geometry and the 2-bit direction counter encodings.
package branch_predictor_pkg;

    localparam int XLEN       = 32;
    localparam int BP_IDX_W   = 6;
    localparam int BP_TAG_W   = 8;

    typedef enum logic [1:0] {
        BP_SNT = 2'b00,
        BP_WNT = 2'b01,
        BP_WT  = 2'b10,
        BP_ST  = 2'b11
    } bp_ctr_e;

endpackage

// File: rtl/branch_predictor_sat_ctr2.sv
// Next-state logic for one 2-bit saturating direction counter.
module bp_sat_ctr2
    import branch_predictor_pkg::*;
(
    input  bp_ctr_e ctr,
    input  logic    taken,
    output bp_ctr_e ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != BP_ST) ctr_next = bp_ctr_e'(ctr + 2'd1);
        end else begin
            if (ctr != BP_SNT) ctr_next = bp_ctr_e'(ctr - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage predictor: 2-bit counter BHT plus direct-mapped BTB, trained by
// the execute stage, with registered mispredict/redirect and statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = BP_IDX_W,
    parameter int TAG_W = BP_TAG_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [XLEN-1:0] upd_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     br_cnt,
    output logic [31:0]     mis_cnt
);

    localparam int ENTRIES = 1 << IDX_W;

    bp_ctr_e         ctr_reg        [ENTRIES];
    logic            btb_valid_reg  [ENTRIES];
    logic [TAG_W-1:0] btb_tag_reg   [ENTRIES];
    logic [XLEN-1:0] btb_target_reg [ENTRIES];

    logic [IDX_W-1:0] if_idx, upd_idx;
    logic [TAG_W-1:0] if_tag, upd_tag;
    logic             if_hit, mis;
    bp_ctr_e          ctr_next;

    logic            mispredict_reg;
    logic [XLEN-1:0] redirect_pc_reg;
    logic [31:0]     br_cnt_reg, mis_cnt_reg;

    // Bits above the tag and the byte offset never take part in indexing.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+TAG_W+2], if_pc[1:0],
                              upd_pc[XLEN-1:IDX_W+TAG_W+2], upd_pc[1:0]};

    assign if_idx  = if_pc[IDX_W+1:2];
    assign if_tag  = if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

    // Lookup reads the registered arrays, so a same-cycle update is not visible yet.
    assign if_hit      = btb_valid_reg[if_idx] && (btb_tag_reg[if_idx] == if_tag);
    assign pred_taken  = if_hit && ctr_reg[if_idx][1];
    assign pred_target = pred_taken ? btb_target_reg[if_idx] : if_pc + XLEN'(4);

    bp_sat_ctr2 u_sat_ctr (
        .ctr      (ctr_reg[upd_idx]),
        .taken    (upd_taken),
        .ctr_next (ctr_next)
    );

    assign mis = (upd_taken != upd_pred_taken) ||
                 (upd_taken && (upd_target != upd_pred_target));

    // Counter trains regardless of BTB hit; aliased branches share a counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_reg[i]        <= BP_WNT;
                btb_valid_reg[i]  <= 1'b0;
                btb_tag_reg[i]    <= '0;
                btb_target_reg[i] <= '0;
            end
        end else if (upd_valid) begin
            ctr_reg[upd_idx] <= ctr_next;
            if (upd_taken) begin
                btb_valid_reg[upd_idx]  <= 1'b1;
                btb_tag_reg[upd_idx]    <= upd_tag;
                btb_target_reg[upd_idx] <= upd_target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict_reg  <= 1'b0;
            redirect_pc_reg <= '0;
            br_cnt_reg      <= '0;
            mis_cnt_reg     <= '0;
        end else begin
            mispredict_reg <= upd_valid && mis;
            if (upd_valid) begin
                redirect_pc_reg <= upd_taken ? upd_target : upd_pc + XLEN'(4);
                if (br_cnt_reg != 32'hFFFF_FFFF) br_cnt_reg <= br_cnt_reg + 32'd1;
                if (mis && (mis_cnt_reg != 32'hFFFF_FFFF)) mis_cnt_reg <= mis_cnt_reg + 32'd1;
            end
        end
    end

    assign mispredict  = mispredict_reg;
    assign redirect_pc = redirect_pc_reg;
    assign br_cnt      = br_cnt_reg;
    assign mis_cnt     = mis_cnt_reg;

endmodule
